pcie_trans_ctrl: RTL and testbench

- Control-plane sequencer for the PCIe transaction-layer datapath: main FIFO (MF) -> virtual-channel FIFOs (VC0/VC1) -> destination FIFOs (D0/D1).
- Runs the link state machine (RESET/INIT/IDLE/ACTIVE/ERROR) and latches the FIFO threshold configuration during INIT.
- Generates the pop/push strobes that move words between FIFO stages with threshold-based back-pressure.
- Drives active_out, idle_out and error_out to the probe side.

---
 rtl/pcie_trans_ctrl_pkg.sv | 23 ++
 rtl/pcie_trans_ctrl_if.sv | 46 ++++
 rtl/pcie_trans_ctrl_vc_arbiter.sv | 37 +++
 rtl/pcie_trans_ctrl.sv | 144 ++++++++++++++
 tb/tb_pcie_trans_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_trans_ctrl_pkg.sv
// Shared definitions for the PCIe transaction-layer control sequencer:
// link state encoding, head-word routing bits and fifo_err bit positions.
package pcie_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // Routing bits inside a datapath word.
    localparam int VC_BIT   = 4;
    localparam int DEST_BIT = 5;

    // Bit positions of the per-FIFO error flags in fifo_err.
    localparam int FIFO_MF  = 0;
    localparam int FIFO_VC0 = 1;
    localparam int FIFO_VC1 = 2;
    localparam int FIFO_D0  = 3;
    localparam int FIFO_D1  = 4;
    localparam int FIFO_NUM = 5;

endpackage

// File: rtl/pcie_trans_ctrl_if.sv
// FIFO-side bundle of the sequencer: status flags and head words coming
// from the FIFOs, pop/push strobes going back to them.
interface pcie_trans_ctrl_if
    import pcie_pkg::*;
#(
    parameter int DATA_W = 6
);
    logic                empty_MF;
    logic                empty_VC0;
    logic                empty_VC1;
    logic                empty_D0;
    logic                empty_D1;
    logic                afull_VC0;
    logic                afull_VC1;
    logic                afull_D0;
    logic                afull_D1;
    logic [FIFO_NUM-1:0] fifo_err;
    logic [DATA_W-1:0]   head_MF;
    logic [DATA_W-1:0]   head_VC0;
    logic [DATA_W-1:0]   head_VC1;
    logic                pop_MF;
    logic                pop_VC0;
    logic                pop_VC1;
    logic                push_VC0;
    logic                push_VC1;
    logic                push_D0;
    logic                push_D1;

    // Sequencer side: reads FIFO status, drives the strobes.
    modport master (
        input  empty_MF, empty_VC0, empty_VC1, empty_D0, empty_D1,
        input  afull_VC0, afull_VC1, afull_D0, afull_D1,
        input  fifo_err, head_MF, head_VC0, head_VC1,
        output pop_MF, pop_VC0, pop_VC1,
        output push_VC0, push_VC1, push_D0, push_D1
    );

    // FIFO side: reports status, consumes the strobes.
    modport slave (
        output empty_MF, empty_VC0, empty_VC1, empty_D0, empty_D1,
        output afull_VC0, afull_VC1, afull_D0, afull_D1,
        output fifo_err, head_MF, head_VC0, head_VC1,
        input  pop_MF, pop_VC0, pop_VC1,
        input  push_VC0, push_VC1, push_D0, push_D1
    );
endinterface

// File: rtl/pcie_trans_ctrl_vc_arbiter.sv
// VC -> destination stage: strict-priority grant (VC0 over VC1) and routing
// of the granted head word to D0/D1 by its destination bit.
module pcie_vc_arbiter
    import pcie_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic              enable,
    input  logic              empty_vc0,
    input  logic              empty_vc1,
    input  logic [DATA_W-1:0] head_vc0,
    input  logic [DATA_W-1:0] head_vc1,
    input  logic              afull_d0,
    input  logic              afull_d1,
    output logic              pop_vc0,
    output logic              pop_vc1,
    output logic              push_d0,
    output logic              push_d1
);
    logic dest0_s;
    logic dest1_s;
    logic tgt0_full_s;
    logic tgt1_full_s;

    // Grant VC0 whenever its target has room; VC1 only takes a free slot.
    always_comb begin
        dest0_s     = head_vc0[DEST_BIT];
        dest1_s     = head_vc1[DEST_BIT];
        tgt0_full_s = dest0_s ? afull_d1 : afull_d0;
        tgt1_full_s = dest1_s ? afull_d1 : afull_d0;
        pop_vc0     = enable && !empty_vc0 && !tgt0_full_s;
        pop_vc1     = enable && !empty_vc1 && !tgt1_full_s && !pop_vc0;
        push_d0     = (pop_vc0 && !dest0_s) || (pop_vc1 && !dest1_s);
        push_d1     = (pop_vc0 &&  dest0_s) || (pop_vc1 &&  dest1_s);
    end

endmodule

// File: rtl/pcie_trans_ctrl.sv
// Link state machine, threshold latching and MF->VC->D strobe generation
// for the PCIe transaction-layer FIFO datapath.
module pcie_trans_ctrl
    import pcie_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int MF_TW  = 2,
    parameter int VC_TW  = 4,
    parameter int D_TW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [MF_TW-1:0] umbral_MF,
    input  logic [VC_TW-1:0] umbral_VC0,
    input  logic [VC_TW-1:0] umbral_VC1,
    input  logic [D_TW-1:0]  umbral_D0,
    input  logic [D_TW-1:0]  umbral_D1,
    pcie_trans_ctrl_if.master bus,
    output logic [MF_TW-1:0] cfg_MF,
    output logic [VC_TW-1:0] cfg_VC0,
    output logic [VC_TW-1:0] cfg_VC1,
    output logic [D_TW-1:0]  cfg_D0,
    output logic [D_TW-1:0]  cfg_D1,
    output logic             active_out,
    output logic             idle_out,
    output logic             error_out
);
    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic       err_s;
    logic       all_empty_s;
    logic       strobe_en_s;
    logic       vc_sel_s;
    logic       pop_mf_s;
    logic       pop_vc0_s;
    logic       pop_vc1_s;
    logic       push_d0_s;
    logic       push_d1_s;
    logic       any_strobe_s;

    // Status summaries; strobes run only in ACTIVE and are cut by a pending
    // reset, init request or FIFO error so nothing moves on those cycles.
    always_comb begin
        err_s       = |bus.fifo_err;
        all_empty_s = bus.empty_MF && bus.empty_VC0 && bus.empty_VC1 &&
                      bus.empty_D0 && bus.empty_D1;
        strobe_en_s = (state_r == ST_ACTIVE) && !reset && !init && !err_s;
    end

    // MF -> VC stage: head word bit selects the VC, stalled by its almost-full.
    always_comb begin
        vc_sel_s = bus.head_MF[VC_BIT];
        pop_mf_s = strobe_en_s && !bus.empty_MF &&
                   !(vc_sel_s ? bus.afull_VC1 : bus.afull_VC0);
    end

    pcie_vc_arbiter #(
        .DATA_W (DATA_W)
    ) u_vc_arbiter (
        .enable    (strobe_en_s),
        .empty_vc0 (bus.empty_VC0),
        .empty_vc1 (bus.empty_VC1),
        .head_vc0  (bus.head_VC0),
        .head_vc1  (bus.head_VC1),
        .afull_d0  (bus.afull_D0),
        .afull_d1  (bus.afull_D1),
        .pop_vc0   (pop_vc0_s),
        .pop_vc1   (pop_vc1_s),
        .push_d0   (push_d0_s),
        .push_d1   (push_d1_s)
    );

    assign bus.pop_MF   = pop_mf_s;
    assign bus.push_VC0 = pop_mf_s && !vc_sel_s;
    assign bus.push_VC1 = pop_mf_s &&  vc_sel_s;
    assign bus.pop_VC0  = pop_vc0_s;
    assign bus.pop_VC1  = pop_vc1_s;
    assign bus.push_D0  = push_d0_s;
    assign bus.push_D1  = push_d1_s;
    assign any_strobe_s = pop_mf_s || pop_vc0_s || pop_vc1_s;

    // Next link state; a FIFO error outranks init and the empty transitions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET: state_nxt_s = ST_INIT;
            ST_INIT: begin
                if (err_s)        state_nxt_s = ST_ERROR;
                else if (!init)   state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_INIT;
            end
            ST_IDLE: begin
                if (err_s)             state_nxt_s = ST_ERROR;
                else if (init)         state_nxt_s = ST_INIT;
                else if (!all_empty_s) state_nxt_s = ST_ACTIVE;
                else                   state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (err_s)                              state_nxt_s = ST_ERROR;
                else if (init)                          state_nxt_s = ST_INIT;
                else if (all_empty_s && !any_strobe_s)  state_nxt_s = ST_IDLE;
                else                                    state_nxt_s = ST_ACTIVE;
            end
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_ERROR;
        endcase
    end

    // State register, indicators decoded from the next state so they change
    // on the same edge as the state, and threshold capture during INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RESET;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
            cfg_MF     <= '0;
            cfg_VC0    <= '0;
            cfg_VC1    <= '0;
            cfg_D0     <= '0;
            cfg_D1     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            active_out <= (state_nxt_s == ST_ACTIVE);
            idle_out   <= (state_nxt_s == ST_IDLE);
            error_out  <= (state_nxt_s == ST_ERROR);
            if ((state_r == ST_INIT) && init && !err_s) begin
                cfg_MF  <= umbral_MF;
                cfg_VC0 <= umbral_VC0;
                cfg_VC1 <= umbral_VC1;
                cfg_D0  <= umbral_D0;
                cfg_D1  <= umbral_D1;
            end else begin
                cfg_MF  <= cfg_MF;
                cfg_VC0 <= cfg_VC0;
                cfg_VC1 <= cfg_VC1;
                cfg_D0  <= cfg_D0;
                cfg_D1  <= cfg_D1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_trans_ctrl.sv
// Self-checking bench for pcie_trans_ctrl: table of strobe vectors in ACTIVE
// plus hand-written sequences for init, drain, error and reset corners.
module tb_pcie_trans_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [1:0] umbral_MF;
    logic [3:0] umbral_VC0;
    logic [3:0] umbral_VC1;
    logic [1:0] umbral_D0;
    logic [1:0] umbral_D1;
    logic [1:0] cfg_MF;
    logic [3:0] cfg_VC0;
    logic [3:0] cfg_VC1;
    logic [1:0] cfg_D0;
    logic [1:0] cfg_D1;
    logic       active_out;
    logic       idle_out;
    logic       error_out;

    int checks = 0;
    int errors = 0;

    pcie_trans_ctrl_if #(.DATA_W(6)) bus ();

    pcie_trans_ctrl #(
        .DATA_W (6),
        .MF_TW  (2),
        .VC_TW  (4),
        .D_TW   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .umbral_MF  (umbral_MF),
        .umbral_VC0 (umbral_VC0),
        .umbral_VC1 (umbral_VC1),
        .umbral_D0  (umbral_D0),
        .umbral_D1  (umbral_D1),
        .bus        (bus),
        .cfg_MF     (cfg_MF),
        .cfg_VC0    (cfg_VC0),
        .cfg_VC1    (cfg_VC1),
        .cfg_D0     (cfg_D0),
        .cfg_D1     (cfg_D1),
        .active_out (active_out),
        .idle_out   (idle_out),
        .error_out  (error_out)
    );

    always #5 clk = ~clk;

    // Strobes packed as {pop_MF, pop_VC0, pop_VC1, push_VC0, push_VC1, push_D0, push_D1}.
    logic [6:0] strobes;
    assign strobes = {bus.pop_MF, bus.pop_VC0, bus.pop_VC1,
                      bus.push_VC0, bus.push_VC1, bus.push_D0, bus.push_D1};

    // empty = {D1,D0,VC1,VC0,MF}, afull = {D1,D0,VC1,VC0}
    typedef struct {
        string      name;
        logic [4:0] empty;
        logic [3:0] afull;
        logic [5:0] h_mf;
        logic [5:0] h_vc0;
        logic [5:0] h_vc1;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs[11];
    logic [6:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_strobes(input logic [6:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic check_strobes(input string name);
        logic [6:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            exp = sb_q.pop_front();
            chk(name, {25'd0, strobes}, {25'd0, exp});
        end
    endtask

    task automatic apply(input vec_t v);
        {bus.empty_D1, bus.empty_D0, bus.empty_VC1, bus.empty_VC0, bus.empty_MF} = v.empty;
        {bus.afull_D1, bus.afull_D0, bus.afull_VC1, bus.afull_VC0} = v.afull;
        bus.head_MF  = v.h_mf;
        bus.head_VC0 = v.h_vc0;
        bus.head_VC1 = v.h_vc1;
    endtask

    task automatic check_ind(input string name, input logic a, input logic i, input logic e);
        chk({name, "_active"}, {31'd0, active_out}, {31'd0, a});
        chk({name, "_idle"},   {31'd0, idle_out},   {31'd0, i});
        chk({name, "_error"},  {31'd0, error_out},  {31'd0, e});
    endtask

    initial begin
        vecs[0]  = '{"mf_to_vc1",       5'b11110, 4'b0000, 6'b010011, 6'b000000, 6'b000000, 7'b1000100};
        vecs[1]  = '{"mf_vc1_afull",    5'b11110, 4'b0010, 6'b010011, 6'b000000, 6'b000000, 7'b0000000};
        vecs[2]  = '{"mf_to_vc0",       5'b11110, 4'b0010, 6'b000111, 6'b000000, 6'b000000, 7'b1001000};
        vecs[3]  = '{"mf_vc0_afull",    5'b11110, 4'b0001, 6'b000001, 6'b000000, 6'b000000, 7'b0000000};
        vecs[4]  = '{"arb_vc0_wins",    5'b11001, 4'b0000, 6'b000000, 6'b000000, 6'b100000, 7'b0100010};
        vecs[5]  = '{"arb_d0_afull",    5'b11001, 4'b0100, 6'b000000, 6'b000000, 6'b100000, 7'b0010001};
        vecs[6]  = '{"arb_d1_afull",    5'b11001, 4'b1000, 6'b000000, 6'b100000, 6'b100000, 7'b0000000};
        vecs[7]  = '{"arb_vc0_to_d1",   5'b11001, 4'b0000, 6'b000000, 6'b100000, 6'b000000, 7'b0100001};
        vecs[8]  = '{"concurrent",      5'b11000, 4'b0000, 6'b010000, 6'b000000, 6'b100000, 7'b1100110};
        vecs[9]  = '{"vc1_alone_to_d0", 5'b11011, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 7'b0010010};
        vecs[10] = '{"only_d_nonempty", 5'b01111, 4'b0000, 6'b010011, 6'b000000, 6'b000000, 7'b0000000};

        reset = 1'b1; init = 1'b0;
        umbral_MF = 2'd0; umbral_VC0 = 4'd0; umbral_VC1 = 4'd0; umbral_D0 = 2'd0; umbral_D1 = 2'd0;
        apply('{"idle", 5'b11111, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 7'b0000000});
        bus.fifo_err = 5'b00000;

        // Reset state
        repeat (2) @(negedge clk);
        check_ind("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_cfg", {18'd0, cfg_MF, cfg_VC0, cfg_VC1, cfg_D0, cfg_D1}, 32'd0);
        expect_strobes(7'b0000000); check_strobes("reset_strobes");

        // Init: three cycles of init=1, then idle two edges after it falls
        reset = 1'b0; init = 1'b1;
        umbral_MF = 2'd3; umbral_VC0 = 4'd5; umbral_VC1 = 4'd9; umbral_D0 = 2'd1; umbral_D1 = 2'd2;
        repeat (3) @(negedge clk);
        check_ind("in_init", 1'b0, 1'b0, 1'b0);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check_ind("post_init", 1'b0, 1'b1, 1'b0);
        chk("cfg_VC0", {28'd0, cfg_VC0}, 32'd5);
        chk("cfg_all", {18'd0, cfg_MF, cfg_VC0, cfg_VC1, cfg_D0, cfg_D1}, {18'd0, 2'd3, 4'd5, 4'd9, 2'd1, 2'd2});

        // IDLE -> ACTIVE once MF is non-empty
        apply(vecs[1]);
        @(negedge clk);
        check_ind("enter_active", 1'b1, 1'b0, 1'b0);

        // Table of strobe vectors in ACTIVE
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            expect_strobes(vecs[i].exp);
            #1;
            check_strobes(vecs[i].name);
            chk({vecs[i].name, "_active"}, {31'd0, active_out}, 32'd1);
            @(negedge clk);
        end

        // init=1 in ACTIVE blocks strobes that cycle and returns to INIT
        apply(vecs[0]); init = 1'b1;
        expect_strobes(7'b0000000); #1; check_strobes("init_blocks");
        @(negedge clk);
        check_ind("active_to_init", 1'b0, 1'b0, 1'b0);
        init = 1'b0;
        @(negedge clk);
        check_ind("init_to_idle", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_ind("idle_to_active", 1'b1, 1'b0, 1'b0);

        // Drain to idle
        apply('{"drain", 5'b11111, 4'b0000, 6'b010011, 6'b000000, 6'b000000, 7'b0000000});
        expect_strobes(7'b0000000); #1; check_strobes("drain_strobes");
        @(negedge clk);
        check_ind("drain", 1'b0, 1'b1, 1'b0);

        // Back to ACTIVE, then a VC1 error
        apply(vecs[0]);
        @(negedge clk);
        expect_strobes(vecs[0].exp); check_strobes("reactivate");
        bus.fifo_err = 5'b00100;
        @(negedge clk);
        check_ind("error", 1'b0, 1'b0, 1'b1);
        expect_strobes(7'b0000000); check_strobes("error_strobes");
        bus.fifo_err = 5'b00000; init = 1'b1;
        repeat (2) @(negedge clk);
        check_ind("error_sticky", 1'b0, 1'b0, 1'b1);
        expect_strobes(7'b0000000); check_strobes("error_sticky_strobes");
        chk("error_cfg_hold", {28'd0, cfg_VC0}, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        check_ind("error_reset", 1'b0, 1'b0, 1'b0);
        chk("error_reset_cfg", {18'd0, cfg_MF, cfg_VC0, cfg_VC1, cfg_D0, cfg_D1}, 32'd0);
        expect_strobes(7'b0000000); check_strobes("error_reset_strobes");

        // Reset mid-transfer drops strobes in the reset cycle
        reset = 1'b0;
        @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check_ind("mid_active", 1'b1, 1'b0, 1'b0);
        expect_strobes(vecs[0].exp); check_strobes("mid_strobes");
        reset = 1'b1;
        expect_strobes(7'b0000000); #1; check_strobes("mid_reset_strobes");
        @(negedge clk);
        check_ind("mid_reset", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
